// File: rtl/rf_write_buffer.sv
// Register-file write buffer: a small circular FIFO of {addr, data} write
// requests that drains one request per cycle into a registered write port.
// Draining pauses while the register file port is stalled. Flush discards
// all buffered requests.
module rf_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     we,
  output logic [AW-1:0]            wAddr,
  output logic [DW-1:0]            wData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addrMem_q [DEPTH];
  logic [DW-1:0] dataMem_q [DEPTH];

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          we_q, we_d;
  logic [AW-1:0] wAddr_q, wAddr_d;
  logic [DW-1:0] wData_q, wData_d;

  logic push;
  logic pop;

  // Status flags come straight from the registered occupancy count, so
  // in_ready has no combinational path from in_valid, stall or flush.
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;

  // A full buffer never accepts, even when it pops on the same edge.
  assign push = in_valid && in_ready && !flush;
  assign pop  = !empty && !stall && !flush;

  assign count = count_q;
  assign we    = we_q;
  assign wAddr = wAddr_q;
  assign wData = wData_q;

  // Next-state logic: pointer advance, occupancy tracking and the write
  // port load. Flush clears the bookkeeping but leaves wAddr/wData holding.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    we_d    = 1'b0;
    wAddr_d = wAddr_q;
    wData_d = wData_q;

    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PW'(1);
        we_d    = 1'b1;
        wAddr_d = addrMem_q[rdPtr_q];
        wData_d = dataMem_q[rdPtr_q];
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      wAddr_q <= '0;
      wData_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      we_q    <= we_d;
      wAddr_q <= wAddr_d;
      wData_q <= wData_d;
    end
  end

  // FIFO storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      addrMem_q[wrPtr_q] <= in_addr;
      dataMem_q[wrPtr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_rf_write_buffer.sv
// Self-checking bench for rf_write_buffer. A queue-based reference model
// tracks what the buffer should hold and what the write port should show.
module tb_rf_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          stall;
  logic          flush;
  logic          we;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] wData;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic          mWe;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mData;

  int nCmp  = 0;
  int nFail = 0;

  rf_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .stall    (stall),
    .flush    (flush),
    .we       (we),
    .wAddr    (wAddr),
    .wData    (wData),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  // Expected packed view of all outputs, derived from the queue model.
  function automatic logic [41:0] modelView();
    return {mWe, mAddr, mData, CW'(mq.size()), (mq.size() == DEPTH),
            (mq.size() == 0), (mq.size() != DEPTH)};
  endfunction

  // Drive one cycle of inputs, advance the model on the edge, settle.
  task automatic tick(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic st, input logic fl, input logic rs);
    bit doPop;
    bit doPush;
    ent_t head;
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    stall    = st;
    flush    = fl;
    reset    = rs;
    @(posedge clk);
    if (rs) begin
      mq.delete();
      mWe = 0; mAddr = '0; mData = '0;
    end else if (fl) begin
      mq.delete();
      mWe = 0;
    end else begin
      doPush = v && (mq.size() < DEPTH);
      doPop  = (mq.size() > 0) && !st;
      mWe = 0;
      if (doPop) begin
        head  = mq.pop_front();
        mWe   = 1;
        mAddr = head.a;
        mData = head.d;
      end
      if (doPush) mq.push_back('{a: a, d: d});
    end
    #1;
  endtask

  task automatic test_reset();
    tick(0, '0, '0, 0, 0, 1);
    nCmp++;
    if ({we, wAddr, wData, count, empty, full, in_ready} !== {1'b0, 3'd0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b1}) begin
      nFail++;
      $display("[TB] FAIL reset_state: got we=%0b wAddr=%0d wData=%h count=%0d empty=%0b full=%0b in_ready=%0b, want 0/0/0/0/1/0/1",
               we, wAddr, wData, count, empty, full, in_ready);
    end
  endtask

  task automatic test_single();
    tick(0, '0, '0, 0, 0, 1);
    tick(1, 3'd0, 32'h11111111, 0, 0, 0);
    nCmp++;
    if (we !== 1'b0 || count !== 3'd1) begin
      nFail++;
      $display("[TB] FAIL single_push: got we=%0b count=%0d, want we=0 count=1", we, count);
    end
    tick(0, '0, '0, 0, 0, 0);
    nCmp++;
    if ({we, wAddr, wData, empty} !== {1'b1, 3'd0, 32'h11111111, 1'b1}) begin
      nFail++;
      $display("[TB] FAIL single_pop: got we=%0b wAddr=%0d wData=%h empty=%0b, want 1/0/11111111/1", we, wAddr, wData, empty);
    end
    tick(0, '0, '0, 0, 0, 0);
    nCmp++;
    if (we !== 1'b0 || empty !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL single_idle: got we=%0b empty=%0b, want we=0 empty=1", we, empty);
    end
  endtask

  task automatic test_full_stall();
    logic [AW-1:0] ea [4];
    logic [DW-1:0] ed [4];
    ea = '{3'd1, 3'd2, 3'd3, 3'd4};
    ed = '{32'hff00ff00, 32'hff00ff00, 32'h0000ffff, 32'h12345678};
    tick(0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick(1, ea[i], ed[i], 1, 0, 0);
    nCmp++;
    if ({count, full, in_ready} !== {3'd4, 1'b1, 1'b0}) begin
      nFail++;
      $display("[TB] FAIL fill_status: got count=%0d full=%0b in_ready=%0b, want 4/1/0", count, full, in_ready);
    end
    tick(1, 3'd5, 32'haaaa5555, 1, 0, 0);
    nCmp++;
    if (count !== 3'd4 || we !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL fifth_ignored: got count=%0d we=%0b, want count=4 we=0", count, we);
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, '0, '0, 0, 0, 0);
      nCmp++;
      if ({we, wAddr, wData} !== {1'b1, ea[i], ed[i]}) begin
        nFail++;
        $display("[TB] FAIL drain_order[%0d]: got we=%0b wAddr=%0d wData=%h, want 1/%0d/%h", i, we, wAddr, wData, ea[i], ed[i]);
      end
    end
    nCmp++;
    if (empty !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL drain_empty: got empty=%0b, want 1", empty);
    end
  endtask

  task automatic test_no_passthrough();
    tick(0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick(1, AW'($urandom), $urandom, 1, 0, 0);
    tick(1, 3'd5, 32'hdeadbeef, 0, 0, 0);
    nCmp++;
    if (count !== 3'd3 || we !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL full_pop_no_push: got count=%0d we=%0b, want count=3 we=1", count, we);
    end
    tick(1, 3'd5, 32'hdeadbeef, 0, 0, 0);
    nCmp++;
    if (count !== 3'd3 || modelView() !== {we, wAddr, wData, count, full, empty, in_ready}) begin
      nFail++;
      $display("[TB] FAIL push_and_pop: got count=%0d we=%0b wAddr=%0d wData=%h, want count=3 model %h",
               count, we, wAddr, wData, modelView());
    end
    for (int i = 0; i < 3; i++) tick(0, '0, '0, 0, 0, 0);
    nCmp++;
    if ({we, wAddr, wData, empty} !== {1'b1, 3'd5, 32'hdeadbeef, 1'b1}) begin
      nFail++;
      $display("[TB] FAIL late_entry: got we=%0b wAddr=%0d wData=%h empty=%0b, want 1/5/deadbeef/1", we, wAddr, wData, empty);
    end
  endtask

  task automatic test_back_to_back();
    tick(0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      tick(1, AW'($urandom), $urandom, 0, 0, 0);
      nCmp++;
      if (count > 3'd1 || (i >= 1 && we !== 1'b1) ||
          modelView() !== {we, wAddr, wData, count, full, empty, in_ready}) begin
        nFail++;
        $display("[TB] FAIL back_to_back[%0d]: got we=%0b wAddr=%0d wData=%h count=%0d, want model %h",
                 i, we, wAddr, wData, count, modelView());
      end
    end
    tick(0, '0, '0, 0, 0, 0);
    nCmp++;
    if (we !== 1'b1 || modelView() !== {we, wAddr, wData, count, full, empty, in_ready}) begin
      nFail++;
      $display("[TB] FAIL back_to_back_tail: got we=%0b wAddr=%0d wData=%h, want model %h", we, wAddr, wData, modelView());
    end
  endtask

  task automatic test_flush();
    tick(0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(1, AW'(i + 1), $urandom, 1, 0, 0);
    tick(1, 3'd7, 32'hcafef00d, 1, 1, 0);
    nCmp++;
    if ({count, empty, we} !== {3'd0, 1'b1, 1'b0}) begin
      nFail++;
      $display("[TB] FAIL flush_clear: got count=%0d empty=%0b we=%0b, want 0/1/0", count, empty, we);
    end
    tick(1, 3'd6, 32'h600d600d, 0, 0, 0);
    nCmp++;
    if (count !== 3'd1) begin
      nFail++;
      $display("[TB] FAIL flush_repush: got count=%0d, want 1", count);
    end
    tick(0, '0, '0, 0, 0, 0);
    nCmp++;
    if ({we, wAddr, wData, empty} !== {1'b1, 3'd6, 32'h600d600d, 1'b1}) begin
      nFail++;
      $display("[TB] FAIL flush_drain: got we=%0b wAddr=%0d wData=%h empty=%0b, want 1/6/600d600d/1", we, wAddr, wData, empty);
    end
  endtask

  task automatic test_reset_mid_drain();
    tick(0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(1, AW'(i + 2), 32'h0a0b0c00 + i, 1, 0, 0);
    tick(0, '0, '0, 0, 0, 0);
    nCmp++;
    if (we !== 1'b1 || count !== 3'd2) begin
      nFail++;
      $display("[TB] FAIL predrain: got we=%0b count=%0d, want we=1 count=2", we, count);
    end
    tick(1, 3'd1, 32'h1, 0, 1, 1);
    nCmp++;
    if ({we, count, wAddr, wData} !== {1'b0, 3'd0, 3'd0, 32'd0}) begin
      nFail++;
      $display("[TB] FAIL reset_mid_drain: got we=%0b count=%0d wAddr=%0d wData=%h, want 0/0/0/0", we, count, wAddr, wData);
    end
  endtask

  task automatic test_random();
    tick(0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      tick(($urandom % 10) < 6, AW'($urandom), $urandom, ($urandom % 10) < 3,
           ($urandom % 20) == 0, ($urandom % 50) == 0);
      nCmp++;
      if ({we, wAddr, wData, count, full, empty, in_ready} !== modelView()) begin
        nFail++;
        $display("[TB] FAIL random[%0d]: got {we,wAddr,wData,count,full,empty,in_ready}=%h, want %h",
                 i, {we, wAddr, wData, count, full, empty, in_ready}, modelView());
      end
    end
  endtask

  initial begin
    reset = 1; in_valid = 0; in_addr = '0; in_data = '0; stall = 0; flush = 0;
    mWe = 0; mAddr = '0; mData = '0;
    test_reset();
    test_single();
    test_full_stall();
    test_no_passthrough();
    test_back_to_back();
    test_flush();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
